// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-class encodings and datapath widths used by the
// writeback buffer and the optional best-score tracker.
package alu_pkg;

  localparam int DATA_W  = 64;
  localparam int SCORE_W = 10;

  typedef enum logic [1:0] {
    SEL_CMP  = 2'b00,
    SEL_PASS = 2'b01,
    SEL_XOR  = 2'b10,
    SEL_ADD  = 2'b11
  } alu_sel_e;

  localparam logic [SCORE_W-1:0] SCORE_INIT = '1;

endpackage

// File: rtl/alu_score_tracker.sv
// Tracks the lowest compare-class score accepted into the writeback buffer.
// Only instantiated when ALU_BEST_SCORE_EN is defined.
module alu_score_tracker
  import alu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               upd_i,
  input  logic [1:0]         sel_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic               clear_i,
  output logic [SCORE_W-1:0] best_score_o,
  output logic               best_valid_o
);

  logic better;

  // Strictly lower only: a tie keeps the earlier score.
  assign better = upd_i && (sel_i == SEL_CMP) &&
                  (!best_valid_o || (score_i < best_score_o));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_score_o <= SCORE_INIT;
      best_valid_o <= 1'b0;
    end else if (clear_i) begin
      best_score_o <= SCORE_INIT;
      best_valid_o <= 1'b0;
    end else if (better) begin
      best_score_o <= score_i;
      best_valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_writeback_buffer.sv
// FIFO between the ALU result mux and register-file writeback, one cycle latency.
// Define ALU_BEST_SCORE_EN to add lowest-compare-score tracking ports.
module alu_writeback_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [DATA_W-1:0]     alu_data_i,
  input  logic [1:0]            alu_select_i,
  input  logic [TAG_W-1:0]      alu_tag_i,
  input  logic                  flush_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic [TAG_W-1:0]      wb_tag_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef ALU_BEST_SCORE_EN
  ,
  output logic [SCORE_W-1:0]    best_score_o,
  output logic                  best_valid_o,
  input  logic                  clear_best_i
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;

  // Ready depends on registered occupancy only, so a full buffer refuses even
  // when the register file drains the head in the same cycle.
  assign alu_ready_o = (count != FULL_CNT);
  assign wb_valid_o  = (count != '0);
  assign push        = alu_valid_i && alu_ready_o;
  assign pop         = wb_valid_o && wb_ready_i;
  assign count_o     = count;
  assign wb_data_o   = mem_data[rd_ptr];
  assign wb_tag_o    = mem_tag[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; validity lives entirely in the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem_data[wr_ptr] <= alu_data_i;
      mem_tag[wr_ptr]  <= alu_tag_i;
    end
  end

`ifdef ALU_BEST_SCORE_EN
  alu_score_tracker u_score (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .upd_i        (push),
    .sel_i        (alu_select_i),
    .score_i      (alu_data_i[SCORE_W-1:0]),
    .clear_i      (clear_best_i),
    .best_score_o (best_score_o),
    .best_valid_o (best_valid_o)
  );
`else
  // The op class only matters to the score tracker.
  logic unused_sel;
  assign unused_sel = ^alu_select_i;
`endif

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Directed self-checking bench for alu_writeback_buffer; score-tracker steps
// run only when ALU_BEST_SCORE_EN is defined.
module tb_alu_writeback_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [63:0] alu_data_i;
  logic [1:0]  alu_select_i;
  logic [3:0]  alu_tag_i;
  logic        flush_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_data_o;
  logic [3:0]  wb_tag_o;
  logic [2:0]  count_o;
`ifdef ALU_BEST_SCORE_EN
  logic [9:0]  best_score_o;
  logic        best_valid_o;
  logic        clear_best_i;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_data [$];
  logic [3:0]  exp_tag  [$];

  always #5 clk_i = ~clk_i;

  alu_writeback_buffer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .alu_valid_i  (alu_valid_i),
    .alu_ready_o  (alu_ready_o),
    .alu_data_i   (alu_data_i),
    .alu_select_i (alu_select_i),
    .alu_tag_i    (alu_tag_i),
    .flush_i      (flush_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_data_o    (wb_data_o),
    .wb_tag_o     (wb_tag_o),
    .count_o      (count_o)
`ifdef ALU_BEST_SCORE_EN
    ,
    .best_score_o (best_score_o),
    .best_valid_o (best_valid_o),
    .clear_best_i (clear_best_i)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic offer(input logic [63:0] d, input logic [3:0] t, input logic [1:0] s);
    alu_valid_i  = 1'b1;
    alu_data_i   = d;
    alu_tag_i    = t;
    alu_select_i = s;
  endtask

  initial begin
    rst_ni = 1'b0; alu_valid_i = 1'b0; alu_data_i = '0; alu_select_i = 2'b01;
    alu_tag_i = '0; flush_i = 1'b0; wb_ready_i = 1'b0;
`ifdef ALU_BEST_SCORE_EN
    clear_best_i = 1'b0;
`endif
    step(); step();
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready_o), 64'd1);
`ifdef ALU_BEST_SCORE_EN
    chk("rst_best_score", 64'(best_score_o), 64'h3FF);
    chk("rst_best_valid", 64'(best_valid_o), 64'd0);
`endif
    rst_ni = 1'b1;
    step();

    // Single push into empty, popped the cycle after it appears.
    offer(64'hA5A5_A5A5_A5A5_A5A5, 4'd3, 2'b01);
    wb_ready_i = 1'b1;
    step();
    alu_valid_i = 1'b0;
    chk("t1_valid", 64'(wb_valid_o), 64'd1);
    chk("t1_data", wb_data_o, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1_tag", 64'(wb_tag_o), 64'd3);
    chk("t1_count1", 64'(count_o), 64'd1);
    step();
    chk("t1_count0", 64'(count_o), 64'd0);
    chk("t1_empty", 64'(wb_valid_o), 64'd0);

    // Fill to full, refuse a fifth offer, drain in order.
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(64'(i + 1) * 64'h1111_1111_1111_1111, 4'(i), 2'b01);
      step();
    end
    chk("t2_full_count", 64'(count_o), 64'd4);
    chk("t2_not_ready", 64'(alu_ready_o), 64'd0);
    offer(64'hDEAD, 4'hF, 2'b01);
    step();
    alu_valid_i = 1'b0;
    chk("t2_refused", 64'(count_o), 64'd4);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_data", wb_data_o, 64'(i + 1) * 64'h1111_1111_1111_1111);
      chk("t2_drain_tag", 64'(wb_tag_o), 64'(i));
      step();
    end
    chk("t2_drained", 64'(count_o), 64'd0);

    // Full with push+pop offered: pop only, then steady flow across wrap.
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(64'(100 + i), 4'(4 + i), 2'b01);
      step();
    end
    offer(64'hBEEF, 4'd8, 2'b01);
    wb_ready_i = 1'b1;
    step();
    chk("t3_full_pop", 64'(count_o), 64'd3);
    exp_data = '{64'd101, 64'd102, 64'd103};
    exp_tag  = '{4'd5, 4'd6, 4'd7};
    for (int k = 0; k < 10; k++) begin
      offer(64'(300 + k), 4'(k), 2'b01);
      chk("t3_head_data", wb_data_o, exp_data[0]);
      chk("t3_head_tag", 64'(wb_tag_o), 64'(exp_tag[0]));
      step();
      void'(exp_data.pop_front());
      void'(exp_tag.pop_front());
      exp_data.push_back(64'(300 + k));
      exp_tag.push_back(4'(k));
      chk("t3_steady_count", 64'(count_o), 64'd3);
    end

    // Flush wins over a simultaneous push and pop.
    offer(64'h77, 4'd1, 2'b01);
    wb_ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; alu_valid_i = 1'b0; wb_ready_i = 1'b0;
    chk("t4_flush_count", 64'(count_o), 64'd0);
    chk("t4_flush_valid", 64'(wb_valid_o), 64'd0);
    chk("t4_flush_ready", 64'(alu_ready_o), 64'd1);

    // Asynchronous reset mid-operation, then a clean first push.
    for (int i = 0; i < 2; i++) begin
      offer(64'(500 + i), 4'(i), 2'b01);
      step();
    end
    alu_valid_i = 1'b0;
    chk("t5_count2", 64'(count_o), 64'd2);
    rst_ni = 1'b0;
    #1;
    chk("t5_async_count", 64'(count_o), 64'd0);
    chk("t5_async_ready", 64'(alu_ready_o), 64'd1);
    chk("t5_async_valid", 64'(wb_valid_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    offer(64'h1234, 4'd9, 2'b01);
    step();
    alu_valid_i = 1'b0;
    chk("t5_post_valid", 64'(wb_valid_o), 64'd1);
    chk("t5_post_data", wb_data_o, 64'h1234);
    chk("t5_post_tag", 64'(wb_tag_o), 64'd9);
    chk("t5_post_count", 64'(count_o), 64'd1);

`ifdef ALU_BEST_SCORE_EN
    // Lowest strictly-smaller compare score wins; other classes ignored.
    wb_ready_i = 1'b1;
    offer(64'd400, 4'd0, 2'b00); step();
    chk("t6_best_400", 64'(best_score_o), 64'd400);
    chk("t6_best_valid", 64'(best_valid_o), 64'd1);
    offer(64'd512, 4'd1, 2'b00); step();
    chk("t6_best_512", 64'(best_score_o), 64'd400);
    offer(64'd399, 4'd2, 2'b00); step();
    chk("t6_best_399", 64'(best_score_o), 64'd399);
    offer(64'd399, 4'd3, 2'b00); step();
    chk("t6_best_tie", 64'(best_score_o), 64'd399);
    offer(64'd5, 4'd4, 2'b11); step();
    chk("t6_best_add", 64'(best_score_o), 64'd399);
    alu_valid_i = 1'b0;
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("t6_flush_keeps", 64'(best_score_o), 64'd399);
    offer(64'd1, 4'd5, 2'b00);
    clear_best_i = 1'b1;
    step();
    clear_best_i = 1'b0; alu_valid_i = 1'b0;
    chk("t6_clear_score", 64'(best_score_o), 64'h3FF);
    chk("t6_clear_valid", 64'(best_valid_o), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
